// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the sequence detector: one frame bit per clock on a registered line.
// Optional even-parity trailer bit is built when SER_PARITY_EN is defined.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

`ifdef SER_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam int CW = 6;
    localparam logic [CW-1:0] LAST_BIT = CW'(FL - 1);
    localparam logic [3:0]    GAP_LAST = 4'(GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             word_done_q, word_done_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif
    logic             accept;
    logic             last_bit;

    function automatic logic first_bit(input logic [WIDTH-1:0] x);
        return MSB_FIRST ? x[WIDTH-1] : x[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] x);
        return MSB_FIRST ? {x[WIDTH-2:0], 1'b0} : {1'b0, x[WIDTH-1:1]};
    endfunction

    assign accept   = in_valid && in_ready_q;
    assign last_bit = (state_q == S_SHIFT) && (cnt_q == LAST_BIT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        sreg_d      = sreg_q;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
`ifdef SER_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d     = S_SHIFT;
                    cnt_d       = '0;
                    sreg_d      = shift_once(in_data);
                    ser_out_d   = first_bit(in_data);
                    ser_valid_d = 1'b1;
`ifdef SER_PARITY_EN
                    par_d       = ^in_data;
`endif
                end
            end
            S_SHIFT: begin
                if (!last_bit) begin
                    cnt_d       = cnt_q + 1'b1;
                    sreg_d      = shift_once(sreg_q);
                    ser_out_d   = first_bit(sreg_q);
                    ser_valid_d = 1'b1;
`ifdef SER_PARITY_EN
                    // The slot after the last data bit carries the parity bit.
                    if ((cnt_q + 1'b1) == CW'(WIDTH)) ser_out_d = par_q;
`endif
                end else if (GAP > 0) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end else if (accept) begin
                    cnt_d       = '0;
                    sreg_d      = shift_once(in_data);
                    ser_out_d   = first_bit(in_data);
                    ser_valid_d = 1'b1;
`ifdef SER_PARITY_EN
                    par_d       = ^in_data;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_IDLE;
                else                   gap_d   = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so the ready/strobe values are derived from the next state.
        word_done_d = ser_valid_d && (cnt_d == LAST_BIT);
        busy_d      = (state_d != S_IDLE);
        in_ready_d  = (state_d == S_IDLE) ||
                      ((GAP == 0) && (state_d == S_SHIFT) && (cnt_d == LAST_BIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            gap_q       <= '0;
            sreg_q      <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            word_done_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
`ifdef SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            sreg_q      <= sreg_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            word_done_q <= word_done_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
`ifdef SER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign word_done = word_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: three instances (MSB/GAP0, LSB/GAP0, MSB/GAP3) with a bit-level scoreboard.
module tb_serial_bit_feeder;
`ifdef SER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d [3];
    logic       v [3];
    logic       rdy [3];
    logic       so [3];
    logic       sv [3];
    logic       wd [3];
    logic       bz [3];

    int tests = 0;
    int fails = 0;
    logic [1:0] q0 [$];
    logic [1:0] q1 [$];
    logic [1:0] q2 [$];
    int  gap_len = 0;
    bit  in_gap  = 0;

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(d[0]), .in_valid(v[0]), .in_ready(rdy[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .word_done(wd[0]), .busy(bz[0]));
    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(d[1]), .in_valid(v[1]), .in_ready(rdy[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .word_done(wd[1]), .busy(bz[1]));
    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(3)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(d[2]), .in_valid(v[2]), .in_ready(rdy[2]),
        .ser_out(so[2]), .ser_valid(sv[2]), .word_done(wd[2]), .busy(bz[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame: data bits in the instance's order, then parity if enabled.
    task automatic push(input int i, input logic [7:0] w);
        logic [1:0] e;
        for (int k = 0; k < FL; k++) begin
            e[0] = (k >= 8) ? ^w : ((i == 1) ? w[k] : w[7-k]);
            e[1] = (k == FL - 1);
            case (i)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    function automatic logic [2:0] pop(input int i);
        logic [1:0] e;
        case (i)
            0: begin if (q0.size() == 0) return 3'b100; e = q0.pop_front(); end
            1: begin if (q1.size() == 0) return 3'b100; e = q1.pop_front(); end
            default: begin if (q2.size() == 0) return 3'b100; e = q2.pop_front(); end
        endcase
        return {1'b0, e};
    endfunction

    task automatic send(input int i, input logic [7:0] w);
        int n = 0;
        d[i] = w;
        v[i] = 1'b1;
        while (rdy[i] !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                tests++; fails++;
                $error("FAIL send_timeout%0d: observed no ready expected ready", i);
                return;
            end
        end
        push(i, w);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 || bz[0] || bz[1] || bz[2]) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                tests++; fails++;
                $error("FAIL drain_timeout: observed busy expected idle");
                return;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                logic [2:0] e;
                if (sv[i]) begin
                    e = pop(i);
                    if (e[2]) begin
                        tests++; fails++;
                        $error("FAIL unexpected%0d: observed valid bit expected none", i);
                    end else begin
                        chk($sformatf("bit%0d", i), so[i], e[0]);
                        chk($sformatf("done%0d", i), wd[i], e[1]);
                        chk($sformatf("busy_on%0d", i), bz[i], 1);
                    end
                end else begin
                    chk($sformatf("idle_out%0d", i), so[i], 0);
                    chk($sformatf("idle_done%0d", i), wd[i], 0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (wd[2]) begin
                in_gap  = 1;
                gap_len = 0;
            end else if (in_gap) begin
                if (bz[2] && !sv[2]) gap_len++;
                else begin
                    chk("gap_len", gap_len, 3);
                    chk("gap_exit_rdy", rdy[2], 1);
                    in_gap = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin d[i] = 8'h00; v[i] = 1'b0; end
        d[0] = 8'hB4;
        v[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rdy", rdy[0], 0);
        chk("rst_ser", so[0], 0);
        chk("rst_vld", sv[0], 0);
        chk("rst_busy", bz[0], 0);
        chk("rst_done", wd[0], 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", rdy[0], 1);
        chk("no_accept_yet", sv[0], 0);

        // Single MSB-first word, then back to idle.
        send(0, 8'hB4);
        v[0] = 1'b0;
        for (int k = 1; k <= FL; k++) begin
            @(negedge clk);
            chk($sformatf("single_rdy_c%0d", k), rdy[0], (k == FL) ? 1 : 0);
        end
        @(negedge clk);
        chk("single_idle_rdy", rdy[0], 1);
        chk("single_idle_busy", bz[0], 0);
        chk("single_idle_vld", sv[0], 0);

        // Back-to-back with in_valid held; second word changes while not ready.
        send(0, 8'hFF);
        d[0] = 8'h00;
        for (int k = 1; k <= FL; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_rdy_c%0d", k), rdy[0], (k == FL) ? 1 : 0);
            chk($sformatf("b2b_vld_c%0d", k), sv[0], 1);
        end
        send(0, 8'h00);
        v[0] = 1'b0;
        @(negedge clk);
        chk("b2b_contig", sv[0], 1);
        drain();

        // LSB first.
        send(1, 8'h07);
        v[1] = 1'b0;
        drain();

        // Gap instance with two queued words.
        send(2, 8'hB4);
        d[2] = 8'h5A;
        for (int k = 1; k <= FL; k++) begin
            @(negedge clk);
            chk($sformatf("gap_rdy_c%0d", k), rdy[2], 0);
        end
        send(2, 8'h5A);
        v[2] = 1'b0;
        drain();

`ifdef SER_PARITY_EN
        send(0, 8'h03);
        v[0] = 1'b0;
        drain();
        send(0, 8'h07);
        v[0] = 1'b0;
        drain();
`endif

        // Reset during bit 4 aborts the frame.
        send(0, 8'hA5);
        v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("abort_pre_vld", sv[0], 1);
        chk("abort_pre_bit", so[0], 0);
        rst_n = 1'b0;
        #1;
        chk("abort_vld", sv[0], 0);
        chk("abort_ser", so[0], 0);
        chk("abort_busy", bz[0], 0);
        chk("abort_done", wd[0], 0);
        chk("abort_rdy", rdy[0], 0);
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_abort_rdy", rdy[0], 1);
        repeat (FL) @(negedge clk);
        chk("post_abort_vld", sv[0], 0);
        chk("post_abort_busy", bz[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
